// File: rtl/phase_accumulator_mc_if.sv
// Control/status bundle for the multi-channel DDS phase accumulator.
// The master drives tuning/offset writes and the step controls; the slave returns per-channel addresses and flags.
interface phase_accumulator_mc_if #(
    parameter int NUM_CH     = 2,
    parameter int TW_WIDTH   = 16,
    parameter int ADDR_WIDTH = 8
) ();
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                         phase_ena;
    logic                         phase_clr;
    logic                         tw_wr;
    logic                         offs_wr;
    logic [CH_W-1:0]              ch_sel;
    logic [TW_WIDTH-1:0]          tw_data;
    logic [ADDR_WIDTH-1:0]        offs_data;
    logic                         update;
    logic [NUM_CH*ADDR_WIDTH-1:0] read_addr;
    logic [NUM_CH-1:0]            wrap;
    logic [NUM_CH-1:0]            pending;

    modport master (
        output phase_ena, phase_clr, tw_wr, offs_wr, ch_sel, tw_data, offs_data, update,
        input  read_addr, wrap, pending
    );

    modport slave (
        input  phase_ena, phase_clr, tw_wr, offs_wr, ch_sel, tw_data, offs_data, update,
        output read_addr, wrap, pending
    );
endinterface

// File: rtl/phase_accumulator_mc.sv
// Multi-channel DDS phase accumulator with double-buffered tuning words and phase offsets.
// Optional truncation dither is enabled by defining PHASE_DITHER_EN; all state updates on the falling clock edge.
module phase_accumulator_mc #(
    parameter int NUM_CH     = 2,
    parameter int ACC_WIDTH  = 16,
    parameter int TW_WIDTH   = 16,
    parameter int ADDR_WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst,
    phase_accumulator_mc_if.slave  bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [ACC_WIDTH-1:0]         acc_q      [NUM_CH];
    logic [ACC_WIDTH-1:0]         acc_d      [NUM_CH];
    logic [ACC_WIDTH:0]           sum_s      [NUM_CH];
    logic [TW_WIDTH-1:0]          tw_act_q   [NUM_CH];
    logic [TW_WIDTH-1:0]          tw_act_d   [NUM_CH];
    logic [TW_WIDTH-1:0]          tw_sh_q    [NUM_CH];
    logic [TW_WIDTH-1:0]          tw_sh_d    [NUM_CH];
    logic [ADDR_WIDTH-1:0]        offs_act_q [NUM_CH];
    logic [ADDR_WIDTH-1:0]        offs_act_d [NUM_CH];
    logic [ADDR_WIDTH-1:0]        offs_sh_q  [NUM_CH];
    logic [ADDR_WIDTH-1:0]        offs_sh_d  [NUM_CH];
    logic [NUM_CH-1:0]            wrap_q;
    logic [NUM_CH-1:0]            wrap_d;
    logic [NUM_CH-1:0]            pending_q;
    logic [NUM_CH-1:0]            pending_d;
    logic [NUM_CH-1:0]            sel_hit_s;
    logic [ACC_WIDTH-1:0]         dither_s;
    logic [NUM_CH*ADDR_WIDTH-1:0] read_addr_s;

    // One accumulator step with the carry kept as the extra MSB.
    function automatic logic [ACC_WIDTH:0] acc_step(
        input logic [ACC_WIDTH-1:0] acc,
        input logic [TW_WIDTH-1:0]  tw
    );
        return (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(tw);
    endfunction

    // Address = top ADDR_WIDTH bits of (acc + dither), then offset added modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] addr_of(
        input logic [ACC_WIDTH-1:0]  acc,
        input logic [ACC_WIDTH-1:0]  dith,
        input logic [ADDR_WIDTH-1:0] offs
    );
        return ADDR_WIDTH'((acc + dith) >> (ACC_WIDTH - ADDR_WIDTH)) + offs;
    endfunction

`ifdef PHASE_DITHER_EN
    localparam int          DITH_W    = ((ACC_WIDTH - ADDR_WIDTH) > 16) ? 16 : (ACC_WIDTH - ADDR_WIDTH);
    localparam logic [15:0] DITH_MASK = 16'((32'd1 << DITH_W) - 32'd1);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Dither source advances only on real accumulation steps.
    always_comb begin
        if (bus.phase_ena && !bus.phase_clr) begin
            lfsr_d = lfsr_next(lfsr_q);
        end else begin
            lfsr_d = lfsr_q;
        end
        dither_s = ACC_WIDTH'(lfsr_q & DITH_MASK);
    end

    // Dither LFSR register.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign dither_s = {ACC_WIDTH{1'b0}};
`endif

    // Channel decode for writes; out-of-range selects hit nothing.
    always_comb begin
        sel_hit_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_sel == CH_W'(i)) begin
                sel_hit_s[i] = 1'b1;
            end else begin
                sel_hit_s[i] = 1'b0;
            end
        end
    end

    // Next-state: accumulate from pre-commit tw, commit from pre-write shadow, then apply writes.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum_s[i]      = acc_step(acc_q[i], tw_act_q[i]);
            acc_d[i]      = acc_q[i];
            wrap_d[i]     = 1'b0;
            tw_act_d[i]   = tw_act_q[i];
            offs_act_d[i] = offs_act_q[i];
            tw_sh_d[i]    = tw_sh_q[i];
            offs_sh_d[i]  = offs_sh_q[i];
            pending_d[i]  = pending_q[i];

            if (bus.phase_clr) begin
                acc_d[i]  = {ACC_WIDTH{1'b0}};
                wrap_d[i] = 1'b0;
            end else if (bus.phase_ena) begin
                acc_d[i]  = sum_s[i][ACC_WIDTH-1:0];
                wrap_d[i] = sum_s[i][ACC_WIDTH];
            end else begin
                acc_d[i]  = acc_q[i];
                wrap_d[i] = 1'b0;
            end

            if (bus.update) begin
                pending_d[i] = 1'b0;
                if (pending_q[i]) begin
                    tw_act_d[i]   = tw_sh_q[i];
                    offs_act_d[i] = offs_sh_q[i];
                end else begin
                    tw_act_d[i]   = tw_act_q[i];
                    offs_act_d[i] = offs_act_q[i];
                end
            end else begin
                pending_d[i] = pending_q[i];
            end

            if (bus.tw_wr && sel_hit_s[i]) begin
                tw_sh_d[i]   = bus.tw_data;
                pending_d[i] = 1'b1;
            end else begin
                tw_sh_d[i] = tw_sh_q[i];
            end

            if (bus.offs_wr && sel_hit_s[i]) begin
                offs_sh_d[i] = bus.offs_data;
                pending_d[i] = 1'b1;
            end else begin
                offs_sh_d[i] = offs_sh_q[i];
            end
        end
    end

    // Per-channel state registers, falling-edge clocked.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]      <= {ACC_WIDTH{1'b0}};
                tw_act_q[i]   <= {TW_WIDTH{1'b0}};
                tw_sh_q[i]    <= {TW_WIDTH{1'b0}};
                offs_act_q[i] <= {ADDR_WIDTH{1'b0}};
                offs_sh_q[i]  <= {ADDR_WIDTH{1'b0}};
            end
            wrap_q    <= {NUM_CH{1'b0}};
            pending_q <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]      <= acc_d[i];
                tw_act_q[i]   <= tw_act_d[i];
                tw_sh_q[i]    <= tw_sh_d[i];
                offs_act_q[i] <= offs_act_d[i];
                offs_sh_q[i]  <= offs_sh_d[i];
            end
            wrap_q    <= wrap_d;
            pending_q <= pending_d;
        end
    end

    // Waveform RAM addresses, combinational from registered state only.
    always_comb begin
        read_addr_s = {(NUM_CH*ADDR_WIDTH){1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            read_addr_s[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_of(acc_q[i], dither_s, offs_act_q[i]);
        end
    end

    assign bus.read_addr = read_addr_s;
    assign bus.wrap      = wrap_q;
    assign bus.pending   = pending_q;
endmodule

// File: tb/tb_phase_accumulator_mc.sv
// Directed bench for phase_accumulator_mc: vector table plus corner sequences
// (full wrap, async reset between edges, out-of-range channel on a 3-channel instance).
module tb_phase_accumulator_mc;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    phase_accumulator_mc_if #(.NUM_CH(2), .TW_WIDTH(16), .ADDR_WIDTH(8)) bus ();
    phase_accumulator_mc_if #(.NUM_CH(3), .TW_WIDTH(16), .ADDR_WIDTH(8)) bus3 ();

    phase_accumulator_mc #(.NUM_CH(2), .ACC_WIDTH(16), .TW_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    phase_accumulator_mc #(.NUM_CH(3), .ACC_WIDTH(16), .TW_WIDTH(16), .ADDR_WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ena;
        logic        clr;
        logic        twwr;
        logic        ofwr;
        logic        ch;
        logic [15:0] tw;
        logic [7:0]  of;
        logic        upd;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [1:0]  wr;
        logic [1:0]  pd;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic ena, input logic clr, input logic twwr, input logic ofwr,
                                input logic ch, input logic [15:0] tw, input logic [7:0] of,
                                input logic upd, input logic [7:0] a0, input logic [7:0] a1,
                                input logic [1:0] wr, input logic [1:0] pd);
        vec_t v;
        v.ena = ena; v.clr = clr; v.twwr = twwr; v.ofwr = ofwr; v.ch = ch; v.tw = tw; v.of = of;
        v.upd = upd; v.a0 = a0; v.a1 = a1; v.wr = wr; v.pd = pd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic drive(input logic ena, input logic clr, input logic twwr, input logic ofwr,
                         input logic ch, input logic [15:0] tw, input logic [7:0] of, input logic upd);
        bus.phase_ena = ena; bus.phase_clr = clr; bus.tw_wr = twwr; bus.offs_wr = ofwr;
        bus.ch_sel = ch; bus.tw_data = tw; bus.offs_data = of; bus.update = upd;
    endtask

    task automatic drive3(input logic ena, input logic twwr, input logic ofwr, input logic [1:0] ch,
                          input logic [15:0] tw, input logic [7:0] of, input logic upd);
        bus3.phase_ena = ena; bus3.phase_clr = 1'b0; bus3.tw_wr = twwr; bus3.offs_wr = ofwr;
        bus3.ch_sel = ch; bus3.tw_data = tw; bus3.offs_data = of; bus3.update = upd;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        drive3(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0);

        //          ena   clr   twwr  ofwr  ch    tw        of     upd   a0     a1     wrap   pend
        tbl[0]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 8'h00, 1'b0, 8'h00, 8'h00, 2'b00, 2'b01);
        tbl[1]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h8000, 8'h40, 1'b0, 8'h00, 8'h00, 2'b00, 2'b11);
        tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h00, 8'h40, 2'b00, 2'b00);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h01, 8'hC0, 2'b00, 2'b00);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h02, 8'h40, 2'b10, 2'b00);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h03, 8'hC0, 2'b00, 2'b00);
        tbl[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h04, 8'h40, 2'b10, 2'b00);
        tbl[7]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0200, 8'h00, 1'b0, 8'h05, 8'hC0, 2'b00, 2'b01);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h06, 8'h40, 2'b10, 2'b00);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h08, 8'hC0, 2'b00, 2'b00);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0200, 8'h00, 1'b0, 8'h08, 8'hC0, 2'b00, 2'b01);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0300, 8'h00, 1'b1, 8'h08, 8'hC0, 2'b00, 2'b01);
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h0A, 8'h40, 2'b10, 2'b01);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h0C, 8'hC0, 2'b00, 2'b00);
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h0F, 8'h40, 2'b10, 2'b00);
        tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h12, 8'hC0, 2'b00, 2'b00);
        tbl[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h40, 2'b00, 2'b00);
        tbl[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h40, 2'b00, 2'b00);
        tbl[18] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h03, 8'hC0, 2'b00, 2'b00);
        tbl[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h03, 8'hC0, 2'b00, 2'b00);
        tbl[20] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 8'hFE, 1'b0, 8'h03, 8'hC0, 2'b00, 2'b01);
        tbl[21] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h04, 8'h40, 2'b10, 2'b00);
        tbl[22] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h04, 8'hC0, 2'b00, 2'b00);

        // Reset state while rst is held through a falling edge.
        #12;
        check("reset read_addr", 32'(bus.read_addr), 32'h0000);
        check("reset wrap", 32'(bus.wrap), 32'h0);
        check("reset pending", 32'(bus.pending), 32'h0);
        #1;
        rst = 1'b1;

`ifndef PHASE_DITHER_EN
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].ena, tbl[i].clr, tbl[i].twwr, tbl[i].ofwr, tbl[i].ch, tbl[i].tw, tbl[i].of, tbl[i].upd);
            step();
            check($sformatf("v%0d addr0", i), 32'(bus.read_addr[7:0]), 32'(tbl[i].a0));
            check($sformatf("v%0d addr1", i), 32'(bus.read_addr[15:8]), 32'(tbl[i].a1));
            check($sformatf("v%0d wrap", i), 32'(bus.wrap), 32'(tbl[i].wr));
            check($sformatf("v%0d pending", i), 32'(bus.pending), 32'(tbl[i].pd));
        end
`else
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h8000, 8'h40, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        step();
`endif

        // Asynchronous reset between falling edges clears outputs at once.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1111, 8'h00, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("async rst read_addr", 32'(bus.read_addr), 32'h0000);
        check("async rst wrap", 32'(bus.wrap), 32'h0);
        check("async rst pending", 32'(bus.pending), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        #1;
        rst = 1'b1;
        step();

`ifndef PHASE_DITHER_EN
        // Full cycle of ch0 at tw=0x0100: one wrap exactly when the address returns to 0.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100, 8'h00, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        for (int k = 1; k <= 256; k++) begin
            logic [8:0] exp_v;
            step();
            exp_v = {(k == 256) ? 1'b1 : 1'b0, 8'(k)};
            check($sformatf("sweep k=%0d {wrap0,addr0}", k), 32'({bus.wrap[0], bus.read_addr[7:0]}), 32'(exp_v));
        end
        check("sweep addr1 untouched", 32'(bus.read_addr[15:8]), 32'h00);
`else
        // Dithered ch0 at tw=0x0080: 1024 steps must advance the address by about 512.
        begin
            int               sum;
            logic [7:0]       prev;
            logic signed [7:0] dl;
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0080, 8'h00, 1'b0);
            step();
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1);
            step();
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
            prev = bus.read_addr[7:0];
            sum  = 0;
            for (int k = 0; k < 1024; k++) begin
                step();
                dl   = $signed(bus.read_addr[7:0] - prev);
                sum  = sum + int'(dl);
                prev = bus.read_addr[7:0];
            end
            check("dither mean step", 32'((sum >= 511 && sum <= 513) ? 1 : 0), 32'd1);
        end
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);

        // Out-of-range channel select on the 3-channel instance is ignored.
        drive3(1'b0, 1'b1, 1'b1, 2'd3, 16'h1234, 8'h55, 1'b0);
        step();
        check("ch3 write pending", 32'(bus3.pending), 32'h0);
        drive3(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1);
        step();
        drive3(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0);
        step();
        check("ch3 write read_addr", 32'(bus3.read_addr), 32'h000000);
        check("ch3 write wrap", 32'(bus3.wrap), 32'h0);
        drive3(1'b0, 1'b1, 1'b0, 2'd2, 16'h4000, 8'h00, 1'b0);
        step();
        check("ch2 write pending", 32'(bus3.pending), 32'h4);
        drive3(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1);
        step();
        drive3(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0);
        step();
        check("ch2 step read_addr", 32'(bus3.read_addr), 32'h400000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
